fetch_sequencer: RTL

- Instruction-fetch sequencer for the 16-bit core. Sits directly upstream of the PC register (N-bit DFF with CE and asynchronous CLR).
- Drives that register's D/CE inputs and reads its O output back as pc_q.
- Runs a request/acknowledge fetch to instruction memory and presents fetched words downstream with a valid/ready handshake.
- Handles taken-branch redirects, including squashing a fetch already in flight.

---
 rtl/fetch_sequencer_if.sv | 23 ++
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 2 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction-memory request/acknowledge plus the
// fetched-word valid/ready stream towards decode.
interface fetch_sequencer_if #(
  parameter int N = 16
);
  logic         mem_req;
  logic [N-1:0] mem_addr;
  logic         mem_ack;
  logic [N-1:0] mem_rdata;
  logic [N-1:0] ir_out;
  logic         ir_valid;
  logic         ir_ready;

  modport master (
    output mem_req, mem_addr, ir_out, ir_valid,
    input  mem_ack, mem_rdata, ir_ready
  );

  modport slave (
    input  mem_req, mem_addr, ir_out, ir_valid,
    output mem_ack, mem_rdata, ir_ready
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: drives the external PC register, runs the
// req/ack memory fetch, and squashes in-flight fetches on branch redirects.
module fetch_sequencer #(
  parameter int N   = 16,
  parameter int INC = 1
) (
  input  logic         C,
  input  logic         CLR,
  input  logic         en,
  input  logic [N-1:0] pc_q,
  output logic [N-1:0] pc_d,
  output logic         pc_ce,
  input  logic         br_taken,
  input  logic [N-1:0] br_target,
  fetch_sequencer_if.master bus,
  output logic [N-1:0] fetch_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [N-1:0] PC_STEP = N'(INC);
  localparam logic [N-1:0] CNT_ONE = N'(1);

  logic [1:0]   state_q,     state_d;
  logic [N-1:0] mem_addr_q,  mem_addr_d;
  logic [N-1:0] ir_out_q,    ir_out_d;
  logic         ir_valid_q,  ir_valid_d;
  logic [N-1:0] fetch_cnt_q, fetch_cnt_d;

  // PC register control is combinational so a redirect lands the same edge;
  // CLR forces it quiet because the PC register is being cleared anyway.
  always_comb begin
    pc_ce = 1'b0;
    pc_d  = pc_q;
    if (CLR) begin
      pc_d = '0;
    end else if (br_taken) begin
      pc_ce = 1'b1;
      pc_d  = br_target;
    end else if (state_q == FETCH && bus.mem_ack) begin
      pc_ce = 1'b1;
      pc_d  = pc_q + PC_STEP;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    ir_out_d    = ir_out_q;
    ir_valid_d  = ir_valid_q;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      IDLE: begin
        if (!br_taken && en) begin
          state_d    = FETCH;
          mem_addr_d = pc_q;
        end
      end

      FETCH: begin
        if (br_taken) begin
          // An acked transfer frees the bus, so the target can go out at once;
          // otherwise the outstanding request must drain through FLUSH.
          if (bus.mem_ack) mem_addr_d = br_target;
          else             state_d    = FLUSH;
        end else if (bus.mem_ack) begin
          ir_out_d    = bus.mem_rdata;
          ir_valid_d  = 1'b1;
          fetch_cnt_d = fetch_cnt_q + CNT_ONE;
          state_d     = HOLD;
        end
      end

      FLUSH: begin
        if (bus.mem_ack) begin
          if (br_taken) begin
            state_d    = FETCH;
            mem_addr_d = br_target;
          end else if (en) begin
            state_d    = FETCH;
            mem_addr_d = pc_q;
          end else begin
            state_d    = IDLE;
          end
        end
      end

      HOLD: begin
        if (br_taken || bus.ir_ready) begin
          ir_valid_d = 1'b0;
          if (en) begin
            state_d    = FETCH;
            mem_addr_d = br_taken ? br_target : pc_q;
          end else begin
            state_d    = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      ir_out_q    <= '0;
      ir_valid_q  <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      ir_out_q    <= ir_out_d;
      ir_valid_q  <= ir_valid_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign bus.mem_req  = (state_q == FETCH) || (state_q == FLUSH);
  assign bus.mem_addr = mem_addr_q;
  assign bus.ir_out   = ir_out_q;
  assign bus.ir_valid = ir_valid_q;
  assign fetch_cnt    = fetch_cnt_q;

endmodule
